time_keeper: RTL

- Timekeeping core that sits directly upstream of the seven-segment controller and drives its 6-bit min and hr buses.
- Divides the system clock down to a 1 Hz tick and keeps a 24-hour time of hours, minutes and seconds.
- Two push-buttons give a set mode for hours and minutes: mode cycles the set state, inc advances the field being set.

---
 rtl/time_keeper.sv | 126 ++++++++++++
 1 files changed

// File: rtl/time_keeper.sv
// 24-hour timekeeping core: divides clk down to a 1 Hz tick, keeps hr:min:sec,
// and provides a two-button set mode (mode cycles RUN/SET_HR/SET_MIN, inc bumps field).
module time_keeper #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned PRESC_W       = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [0:5] hr,
  output logic [0:5] min,
  output logic [0:5] sec,
  output logic [0:1] set_mode,
  output logic       sec_tick
);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StSetHr  = 2'b01,
    StSetMin = 2'b10
  } state_e;

  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(TICKS_PER_SEC - 1);

  // [0],[1]: two-flop synchronizer; [2]: previous synchronized level for edge detect
  logic [2:0] mode_sync, inc_sync;
  logic       mode_p, inc_p;

  state_e             state;
  logic [PRESC_W-1:0] presc;
  logic [5:0]         hr_q, min_q, sec_q;
  logic               tick_q;

  logic wrap, sec_last, min_last, hr_last;

  // Wrap/carry conditions; >= keeps any corrupted value from escaping its range
  assign wrap     = (state == StRun) && (presc >= PrescLast);
  assign sec_last = (sec_q >= 6'd59);
  assign min_last = (min_q >= 6'd59);
  assign hr_last  = (hr_q >= 6'd23);

  // Synchronize buttons and register a one-cycle pulse on each rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sync <= 3'b000;
      inc_sync  <= 3'b000;
      mode_p    <= 1'b0;
      inc_p     <= 1'b0;
    end else begin
      mode_sync <= {mode_sync[1:0], btn_mode};
      inc_sync  <= {inc_sync[1:0], btn_inc};
      mode_p    <= mode_sync[1] & ~mode_sync[2];
      inc_p     <= inc_sync[1] & ~inc_sync[2];
    end
  end

  // Set-mode FSM, prescaler and time registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= StRun;
      presc  <= '0;
      hr_q   <= 6'd0;
      min_q  <= 6'd0;
      sec_q  <= 6'd0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state)
        StRun: begin
          if (wrap) begin
            presc  <= '0;
            tick_q <= 1'b1;
            if (sec_last) begin
              sec_q <= 6'd0;
              if (min_last) begin
                min_q <= 6'd0;
                hr_q  <= hr_last ? 6'd0 : hr_q + 6'd1;
              end else begin
                min_q <= min_q + 6'd1;
              end
            end else begin
              sec_q <= sec_q + 6'd1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
          // A coincident tick is still applied above; the prescaler then parks at 0
          if (mode_p) begin
            state <= StSetHr;
            presc <= '0;
          end
        end
        StSetHr: begin
          presc <= '0;
          if (mode_p) begin
            state <= StSetMin;
          end else if (inc_p) begin
            hr_q <= hr_last ? 6'd0 : hr_q + 6'd1;
          end
        end
        StSetMin: begin
          presc <= '0;
          if (mode_p) begin
            // Restart the second so the first tick lands a full period after exit
            state <= StRun;
            sec_q <= 6'd0;
          end else if (inc_p) begin
            min_q <= min_last ? 6'd0 : min_q + 6'd1;
          end
        end
        default: begin
          state <= StRun;
          presc <= '0;
        end
      endcase
    end
  end

  assign hr       = hr_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign set_mode = state;
  assign sec_tick = tick_q;

endmodule
